// File: rtl/uart_wb_top_pkg.sv
// Shared constants and state types for the UART-to-Wishbone bridge.
package uart_wb_top_pkg;
  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  localparam logic [7:0] STAT_OK      = 8'h01;
  localparam logic [7:0] STAT_TIMEOUT = 8'hEE;

  typedef enum logic [2:0] {RX_CMD, RX_ADDR, RX_DATA, BUS, TX_RESP} state_e;
  typedef enum logic [1:0] {URX_IDLE, URX_START, URX_DATA, URX_STOP} urx_state_e;
endpackage

// File: rtl/uart_wb_top_uartrx.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit, drops bytes with a bad stop bit.
module uartrx
  import uart_wb_top_pkg::*;
#(
  parameter int BAUD_PER = 868
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       valid
);
  localparam int CW = $clog2(BAUD_PER);
  localparam logic [CW-1:0] LAST = CW'(BAUD_PER - 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_PER / 2 - 1);

  urx_state_e     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     sh_q, sh_d;
  logic [7:0]     dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= URX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Sample points sit BAUD_PER/2 after the detected edge, then every BAUD_PER.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    valid_d = 1'b0;
    case (state_q)
      URX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = URX_START;
      end
      URX_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = sync2_q ? URX_IDLE : URX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      URX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          sh_d  = {sync2_q, sh_q[7:1]};
          bit_d = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = URX_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      URX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = URX_IDLE;
          if (sync2_q) begin
            dout_d  = sh_q;
            valid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = URX_IDLE;
    endcase
    if (!en) state_d = URX_IDLE;
  end

  assign dout  = dout_q;
  assign valid = valid_q;
endmodule

// File: rtl/uart_wb_top_uarttx.sv
// 8N1 UART transmitter: latches a byte when ready, shifts start/data/stop out.
module uarttx #(
  parameter int BAUD_PER = 868
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic [7:0] din,
  output logic       tx,
  output logic       ready
);
  localparam int CW = $clog2(BAUD_PER);
  localparam logic [CW-1:0] LAST = CW'(BAUD_PER - 1);

  logic          ready_q, ready_d;
  logic          tx_q, tx_d;
  logic [8:0]    sh_q, sh_d;
  logic [3:0]    bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ready_q <= 1'b1;
      tx_q    <= 1'b1;
      sh_q    <= '1;
      bit_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ready_q <= ready_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  // sh_q holds the bits still to go; the stop bit is the top 1 shifted in.
  always_comb begin
    ready_d = ready_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    if (ready_q) begin
      if (en) begin
        ready_d = 1'b0;
        tx_d    = 1'b0;
        sh_d    = {1'b1, din};
        bit_d   = '0;
        cnt_d   = '0;
      end
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
      if (bit_q == 4'd9) begin
        ready_d = 1'b1;
      end else begin
        tx_d  = sh_q[0];
        sh_d  = {1'b1, sh_q[8:1]};
        bit_d = bit_q + 1'b1;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
endmodule

// File: rtl/uart_wb_top.sv
// UART-to-Wishbone bridge: 9-byte command frames become single classic bus
// cycles, answered with a status byte plus read data.
module uart_wb_top
  import uart_wb_top_pkg::*;
#(
  parameter int BAUD_PER   = 868,
  parameter int WB_TIMEOUT = 1024
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        m_wb_clk_o,
  output logic [31:0] m_wb_addr_o,
  output logic [31:0] m_wb_data_o,
  input  logic [31:0] m_wb_data_i,
  output logic        m_wb_we_o,
  output logic        m_wb_cyc_o,
  output logic        m_wb_stb_o,
  input  logic        m_wb_ack_i
);
  localparam int TW = $clog2(WB_TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(WB_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    stat_q, stat_d;
  logic          cyc_q, cyc_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    resp_q, resp_d;

  logic       rx_en, rx_valid, tx_en, tx_ready;
  logic [7:0] rx_dout, tx_din;
  logic [2:0] resp_last;

  // Receiving is only enabled while a frame is being collected.
  assign rx_en = (state_q == RX_CMD) || (state_q == RX_ADDR) || (state_q == RX_DATA);

  uartrx #(.BAUD_PER(BAUD_PER)) u_rx (
    .clk(clk_i), .nrst(nrst_i), .en(rx_en), .rx(uart_rx),
    .dout(rx_dout), .valid(rx_valid)
  );

  uarttx #(.BAUD_PER(BAUD_PER)) u_tx (
    .clk(clk_i), .nrst(nrst_i), .en(tx_en), .din(tx_din),
    .tx(uart_tx), .ready(tx_ready)
  );

  assign resp_last = (we_q == CMD_READ) ? 3'd4 : 3'd0;
  assign tx_en     = (state_q == TX_RESP) && tx_ready && (resp_q <= resp_last);

  always_comb begin
    case (resp_q)
      3'd0:    tx_din = stat_q;
      3'd1:    tx_din = rdata_q[31:24];
      3'd2:    tx_din = rdata_q[23:16];
      3'd3:    tx_din = rdata_q[15:8];
      default: tx_din = rdata_q[7:0];
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q <= RX_CMD;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      stat_q  <= '0;
      cyc_q   <= 1'b0;
      timer_q <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      stat_q  <= stat_d;
      cyc_q   <= cyc_d;
      timer_q <= timer_d;
      resp_q  <= resp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    stat_d  = stat_q;
    cyc_d   = cyc_q;
    timer_d = timer_q;
    resp_d  = resp_q;
    case (state_q)
      RX_CMD: begin
        if (rx_valid) begin
          we_d    = (rx_dout[0] == CMD_WRITE);
          cnt_d   = '0;
          state_d = RX_ADDR;
        end
      end
      RX_ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_dout};
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == 2'd3) state_d = RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_dout};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == 2'd3) begin
            state_d = BUS;
            cyc_d   = 1'b1;
            timer_d = '0;
          end
        end
      end
      BUS: begin
        if (m_wb_ack_i) begin
          cyc_d   = 1'b0;
          stat_d  = STAT_OK;
          rdata_d = we_q ? 32'h0 : m_wb_data_i;
          resp_d  = '0;
          state_d = TX_RESP;
        end else if (timer_q == TLAST) begin
          cyc_d   = 1'b0;
          stat_d  = STAT_TIMEOUT;
          rdata_d = 32'h0;
          resp_d  = '0;
          state_d = TX_RESP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      TX_RESP: begin
        // Stay until the last byte has left the transmitter completely.
        if (tx_en) begin
          resp_d = resp_q + 1'b1;
        end else if (resp_q > resp_last && tx_ready) begin
          state_d = RX_CMD;
        end
      end
      default: state_d = RX_CMD;
    endcase
  end

  assign m_wb_clk_o  = clk_i;
  assign m_wb_addr_o = addr_q;
  assign m_wb_data_o = wdata_q;
  assign m_wb_we_o   = cyc_q & we_q;
  assign m_wb_cyc_o  = cyc_q;
  assign m_wb_stb_o  = cyc_q;
endmodule

// File: tb/tb_uart_wb_top.sv
// Scoreboard bench for uart_wb_top plus standalone checks of uartrx/uarttx.
`timescale 1ns/1ps
module tb_uart_wb_top;
  localparam int BAUD = 10;
  localparam int TMO  = 64;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        hostRx = 1'b1;
  logic        uartTx, wbClk, wbWe, wbCyc, wbStb, wbAck;
  logic [31:0] wbAddr, wbDataO, wbDataI;

  logic        leafTxEn = 1'b0;
  logic [7:0]  leafTxDin = 8'h00;
  logic        leafTx, leafTxReady;
  logic        leafRx = 1'b1;
  logic [7:0]  leafRxDout;
  logic        leafRxValid;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  uart_wb_top #(.BAUD_PER(BAUD), .WB_TIMEOUT(TMO)) dut (
    .clk_i(clk), .nrst_i(nrst), .uart_rx(hostRx), .uart_tx(uartTx),
    .m_wb_clk_o(wbClk), .m_wb_addr_o(wbAddr), .m_wb_data_o(wbDataO),
    .m_wb_data_i(wbDataI), .m_wb_we_o(wbWe), .m_wb_cyc_o(wbCyc),
    .m_wb_stb_o(wbStb), .m_wb_ack_i(wbAck)
  );

  uarttx #(.BAUD_PER(BAUD)) leafTxInst (
    .clk(clk), .nrst(nrst), .en(leafTxEn), .din(leafTxDin),
    .tx(leafTx), .ready(leafTxReady)
  );

  uartrx #(.BAUD_PER(BAUD)) leafRxInst (
    .clk(clk), .nrst(nrst), .en(1'b1), .rx(leafRx),
    .dout(leafRxDout), .valid(leafRxValid)
  );

  // Zero-wait slave that only answers addresses 0..15.
  logic [31:0] slaveMem [0:15];
  assign wbAck   = wbCyc && wbStb && (wbAddr < 32'd16);
  assign wbDataI = (wbAddr < 32'd16) ? slaveMem[wbAddr[3:0]] : 32'h0;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 16; i++) slaveMem[i] <= (i == 2) ? 32'd2 : 32'd0;
    end else if (wbAck && wbWe) begin
      slaveMem[wbAddr[3:0]] <= wbDataO;
    end
  end

  // Bus activity recorder.
  int          busStarts = 0;
  int          cycCycles = 0;
  logic        cycPrev = 1'b0;
  logic [31:0] lastAddr = '0, lastData = '0;
  logic        lastWe = 1'b0;
  int          validCnt = 0;

  always @(negedge clk) begin
    cycPrev <= wbCyc;
    if (leafRxValid) validCnt <= validCnt + 1;
    if (wbCyc) begin
      cycCycles <= cycCycles + 1;
      if (!cycPrev) begin
        busStarts <= busStarts + 1;
        lastAddr  <= wbAddr;
        lastData  <= wbDataO;
        lastWe    <= wbWe;
      end
    end
  end

  // Serial decoder for the bridge output.
  logic [7:0] rxMem [0:63];
  logic [7:0] monByte;
  int         rxCount = 0;
  int         rdIdx = 0;

  initial begin
    monByte = 8'h00;
    forever begin
      @(negedge clk);
      if (nrst && uartTx === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          monByte[i] = uartTx;
        end
        repeat (BAUD) @(negedge clk);
        rxMem[rxCount[5:0]] = monByte;
        rxCount = rxCount + 1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got %0d/%0d", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  logic [31:0] modelMem [0:15];
  logic [7:0]  expQ [$];

  task automatic setLine(input bit toLeaf, input logic v);
    if (toLeaf) leafRx = v;
    else hostRx = v;
  endtask

  task automatic sendSerial(input logic [7:0] b, input logic stopBit, input bit toLeaf);
    @(negedge clk);
    setLine(toLeaf, 1'b0);
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      setLine(toLeaf, b[i]);
      repeat (BAUD) @(negedge clk);
    end
    setLine(toLeaf, stopBit);
    repeat (BAUD) @(negedge clk);
    setLine(toLeaf, 1'b1);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) modelMem[i] = (i == 2) ? 32'd2 : 32'd0;
  endtask

  // Sends one frame and, when a reply is due, queues the expected reply bytes.
  task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] addr,
                               input logic [31:0] data, input bit expectResp);
    logic [7:0]  frame [9];
    logic [31:0] rd;
    bit          hit;
    hit = (addr < 32'd16);
    if (expectResp) begin
      if (cmd[0]) begin
        if (hit) modelMem[addr[3:0]] = data;
        expQ.push_back(hit ? 8'h01 : 8'hEE);
      end else begin
        rd = hit ? modelMem[addr[3:0]] : 32'h0;
        expQ.push_back(hit ? 8'h01 : 8'hEE);
        expQ.push_back(rd[31:24]);
        expQ.push_back(rd[23:16]);
        expQ.push_back(rd[15:8]);
        expQ.push_back(rd[7:0]);
      end
    end
    frame[0] = cmd;
    frame[1] = addr[31:24]; frame[2] = addr[23:16]; frame[3] = addr[15:8]; frame[4] = addr[7:0];
    frame[5] = data[31:24]; frame[6] = data[23:16]; frame[7] = data[15:8]; frame[8] = data[7:0];
    repeat (2 * BAUD) @(negedge clk);
    for (int i = 0; i < 9; i++) sendSerial(frame[i], 1'b1, 1'b0);
  endtask

  task automatic waitTxByte(output logic [7:0] b, output bit ok);
    int n = 0;
    while (rxCount <= rdIdx && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = (rxCount > rdIdx);
    b  = ok ? rxMem[rdIdx[5:0]] : 8'h00;
    if (ok) rdIdx++;
  endtask

  task automatic test_reset();
    modelReset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (uartTx !== 1'b1) $display("[TB] FAIL reset_tx got %b want 1", uartTx); else passes++;
    checks++; if (wbCyc !== 1'b0) $display("[TB] FAIL reset_cyc got %b want 0", wbCyc); else passes++;
    checks++; if (wbStb !== 1'b0) $display("[TB] FAIL reset_stb got %b want 0", wbStb); else passes++;
    checks++; if (wbWe !== 1'b0) $display("[TB] FAIL reset_we got %b want 0", wbWe); else passes++;
    checks++; if (wbAddr !== 32'h0) $display("[TB] FAIL reset_addr got %h want 0", wbAddr); else passes++;
    checks++; if (wbDataO !== 32'h0) $display("[TB] FAIL reset_data got %h want 0", wbDataO); else passes++;
    checks++; if (wbClk !== clk) $display("[TB] FAIL wb_clk got %b want %b", wbClk, clk); else passes++;
    checks++; if (leafTxReady !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", leafTxReady); else passes++;
    checks++; if (leafRxValid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", leafRxValid); else passes++;
    checks++; if (leafRxDout !== 8'h00) $display("[TB] FAIL reset_dout got %h want 00", leafRxDout); else passes++;
    nrst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_read();
    logic [7:0] got, exp;
    bit ok;
    int s0 = busStarts;
    applyStimulus(8'h00, 32'd2, 32'hDEADBEEF, 1'b1);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      waitTxByte(got, ok);
      checks++;
      if (!ok || got !== exp) $display("[TB] FAIL read_byte got %h (ok=%0d) want %h", got, ok, exp);
      else passes++;
    end
    checks++; if (busStarts - s0 != 1) $display("[TB] FAIL read_cycles got %0d want 1", busStarts - s0); else passes++;
    checks++; if (lastWe !== 1'b0 || lastAddr !== 32'd2) $display("[TB] FAIL read_bus got we=%b addr=%h want we=0 addr=2", lastWe, lastAddr); else passes++;
  endtask

  task automatic test_write();
    logic [7:0] got, exp;
    bit ok;
    int s0 = busStarts;
    int c0 = cycCycles;
    applyStimulus(8'h81, 32'd3, 32'hABCD1234, 1'b1);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      waitTxByte(got, ok);
      checks++;
      if (!ok || got !== exp) $display("[TB] FAIL write_resp got %h (ok=%0d) want %h", got, ok, exp);
      else passes++;
    end
    checks++; if (busStarts - s0 != 1) $display("[TB] FAIL write_cycles got %0d want 1", busStarts - s0); else passes++;
    checks++; if (cycCycles - c0 != 1) $display("[TB] FAIL write_cyc_len got %0d want 1", cycCycles - c0); else passes++;
    checks++; if (lastWe !== 1'b1) $display("[TB] FAIL write_we got %b want 1", lastWe); else passes++;
    checks++; if (lastAddr !== 32'd3) $display("[TB] FAIL write_addr got %h want 3", lastAddr); else passes++;
    checks++; if (lastData !== 32'hABCD1234) $display("[TB] FAIL write_data got %h want abcd1234", lastData); else passes++;
    applyStimulus(8'hFE, 32'd3, 32'h0, 1'b1);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      waitTxByte(got, ok);
      checks++;
      if (!ok || got !== exp) $display("[TB] FAIL readback_byte got %h (ok=%0d) want %h", got, ok, exp);
      else passes++;
    end
  endtask

  task automatic test_timeout();
    logic [7:0] got, exp;
    bit ok;
    int s0 = busStarts;
    int c0 = cycCycles;
    applyStimulus(8'h00, 32'd100, 32'h0, 1'b1);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      waitTxByte(got, ok);
      checks++;
      if (!ok || got !== exp) $display("[TB] FAIL timeout_byte got %h (ok=%0d) want %h", got, ok, exp);
      else passes++;
    end
    checks++; if (busStarts - s0 != 1) $display("[TB] FAIL timeout_cycles got %0d want 1", busStarts - s0); else passes++;
    checks++; if (cycCycles - c0 != TMO) $display("[TB] FAIL timeout_cyc_len got %0d want %0d", cycCycles - c0, TMO); else passes++;
    applyStimulus(8'h00, 32'd2, 32'h0, 1'b1);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      waitTxByte(got, ok);
      checks++;
      if (!ok || got !== exp) $display("[TB] FAIL after_timeout_byte got %h (ok=%0d) want %h", got, ok, exp);
      else passes++;
    end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] got, exp;
    bit ok;
    int s0;
    repeat (2 * BAUD) @(negedge clk);
    sendSerial(8'h01, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) sendSerial(8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    nrst = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    s0 = busStarts;
    applyStimulus(8'h00, 32'd2, 32'h0, 1'b1);
    while (expQ.size() > 0) begin
      exp = expQ.pop_front();
      waitTxByte(got, ok);
      checks++;
      if (!ok || got !== exp) $display("[TB] FAIL midframe_byte got %h (ok=%0d) want %h", got, ok, exp);
      else passes++;
    end
    checks++; if (busStarts - s0 != 1) $display("[TB] FAIL midframe_cycles got %0d want 1", busStarts - s0); else passes++;
    checks++; if (lastWe !== 1'b0 || lastAddr !== 32'd2) $display("[TB] FAIL midframe_bus got we=%b addr=%h want we=0 addr=2", lastWe, lastAddr); else passes++;
  endtask

  task automatic test_reset_midbus();
    int n = 0;
    applyStimulus(8'h00, 32'd100, 32'h0, 1'b0);
    while (!wbCyc && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++; if (wbCyc !== 1'b1) $display("[TB] FAIL midbus_start got cyc=%b want 1", wbCyc); else passes++;
    repeat (5) @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++; if (wbCyc !== 1'b0 || wbStb !== 1'b0) $display("[TB] FAIL midbus_async got cyc=%b stb=%b want 0 0", wbCyc, wbStb); else passes++;
    checks++; if (wbAddr !== 32'h0) $display("[TB] FAIL midbus_addr got %h want 0", wbAddr); else passes++;
    modelReset();
    repeat (3) @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_uarttx();
    logic [9:0] expBits;
    logic [7:0] din = 8'hA5;
    expBits = {1'b1, din, 1'b0};
    @(negedge clk);
    leafTxDin = din;
    leafTxEn  = 1'b1;
    @(negedge clk);
    leafTxEn  = 1'b0;
    checks++; if (leafTxReady !== 1'b0) $display("[TB] FAIL tx_ready_low got %b want 0", leafTxReady); else passes++;
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? BAUD / 2 : BAUD) @(negedge clk);
      checks++;
      if (leafTx !== expBits[k]) $display("[TB] FAIL tx_bit%0d got %b want %b", k, leafTx, expBits[k]);
      else passes++;
    end
    repeat (4) @(negedge clk);
    checks++; if (leafTxReady !== 1'b0) $display("[TB] FAIL tx_ready_early got %b want 0", leafTxReady); else passes++;
    @(negedge clk);
    checks++; if (leafTxReady !== 1'b1) $display("[TB] FAIL tx_ready_back got %b want 1", leafTxReady); else passes++;
  endtask

  task automatic test_uartrx();
    int v0 = validCnt;
    sendSerial(8'h55, 1'b0, 1'b1);
    repeat (3 * BAUD) @(negedge clk);
    checks++; if (validCnt != v0) $display("[TB] FAIL rx_framing got %0d pulses want 0", validCnt - v0); else passes++;
    checks++; if (leafRxDout !== 8'h00) $display("[TB] FAIL rx_framing_dout got %h want 00", leafRxDout); else passes++;
    sendSerial(8'h3C, 1'b1, 1'b1);
    repeat (2 * BAUD) @(negedge clk);
    checks++; if (validCnt - v0 != 1) $display("[TB] FAIL rx_valid_len got %0d want 1", validCnt - v0); else passes++;
    checks++; if (leafRxDout !== 8'h3C) $display("[TB] FAIL rx_dout got %h want 3c", leafRxDout); else passes++;
  endtask

  task automatic test_no_stray();
    repeat (20 * BAUD) @(negedge clk);
    checks++;
    if (rxCount != rdIdx) $display("[TB] FAIL stray_bytes got %0d want %0d", rxCount, rdIdx);
    else passes++;
  endtask

  initial begin
    $display("[TB] starting uart_wb_top bench");
    test_reset();
    test_read();
    test_write();
    test_timeout();
    test_reset_midframe();
    test_reset_midbus();
    test_uarttx();
    test_uartrx();
    test_no_stray();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
